// File: rtl/control_unit_if.sv
// control_unit_if: instruction/flag inputs and control strobe outputs
// exchanged between the datapath (master side) and control_unit (slave side).
interface control_unit_if #(
  parameter int CNT_W = 16
) ();
  // Inputs to the control unit
  logic             start;
  logic [15:0]      instr;
  logic             Pre_C;
  logic             Pre_V;
  logic             Pre_Z;
  logic             Pre_N;

  // Mode / status outputs
  logic             test_normal;
  logic             flag_HLT;
  logic [3:0]       flags;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  // Datapath control strobes
  logic ADC, SUB, SBB, JMP, BRANCH;
  logic flag_label_PC, flag_Rm_PC, flag_Rd_PC;
  logic Src_ALU_B, Src_Read_B, data_write_en;
  logic flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF;
  logic RF_write_en, LHI, LLI, flag_OutR;

  modport master (
    output start, instr, Pre_C, Pre_V, Pre_Z, Pre_N,
    input  test_normal, flag_HLT, flags, halted, illegal, instr_count,
    input  ADC, SUB, SBB, JMP, BRANCH,
    input  flag_label_PC, flag_Rm_PC, flag_Rd_PC,
    input  Src_ALU_B, Src_Read_B, data_write_en,
    input  flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF,
    input  RF_write_en, LHI, LLI, flag_OutR
  );

  modport slave (
    input  start, instr, Pre_C, Pre_V, Pre_Z, Pre_N,
    output test_normal, flag_HLT, flags, halted, illegal, instr_count,
    output ADC, SUB, SBB, JMP, BRANCH,
    output flag_label_PC, flag_Rm_PC, flag_Rd_PC,
    output Src_ALU_B, Src_Read_B, data_write_en,
    output flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF,
    output RF_write_en, LHI, LLI, flag_OutR
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: decode, program-load/run/halt FSM, NZCV flag register,
// branch condition evaluation and saturating retired-instruction counter
// for the single-cycle RISC.
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, an undefined
// opcode in RUN halts the machine and sets the sticky illegal flag instead
// of executing as a NOP.
module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          clr,
  control_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  logic             cond_true;
  logic             n_f, z_f, c_f, v_f;
  logic [4:0]       op;
  logic [1:0]       funct;
  logic             unused_instr_bits;

  assign op                = bus.instr[15:11];
  assign funct             = bus.instr[1:0];
  assign {n_f, z_f, c_f, v_f} = flags_q;
  // Operand/register fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^bus.instr[7:2];

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Branch condition code evaluated against the registered (old) flags
  always_comb begin
    cond_true = 1'b0;
    case (bus.instr[11:8])
      4'h0:    cond_true = z_f;
      4'h1:    cond_true = !z_f;
      4'h2:    cond_true = c_f;
      4'h3:    cond_true = !c_f;
      4'h4:    cond_true = n_f;
      4'h5:    cond_true = !n_f;
      4'h6:    cond_true = v_f;
      4'h7:    cond_true = !v_f;
      4'h8:    cond_true = c_f && !z_f;
      4'h9:    cond_true = !c_f || z_f;
      4'hA:    cond_true = (n_f == v_f);
      4'hB:    cond_true = (n_f != v_f);
      4'hC:    cond_true = !z_f && (n_f == v_f);
      4'hD:    cond_true = z_f || (n_f != v_f);
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state, decode strobes and register next values
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d            = state_q;
    flags_d            = flags_q;
    count_d            = count_q;
    retire             = 1'b0;
    bus.test_normal    = 1'b0;
    bus.flag_HLT       = 1'b0;
    bus.halted         = 1'b0;
    bus.ADC            = 1'b0;
    bus.SUB            = 1'b0;
    bus.SBB            = 1'b0;
    bus.JMP            = 1'b0;
    bus.BRANCH         = 1'b0;
    bus.flag_label_PC  = 1'b0;
    bus.flag_Rm_PC     = 1'b0;
    bus.flag_Rd_PC     = 1'b0;
    bus.Src_ALU_B      = 1'b0;
    bus.Src_Read_B     = 1'b0;
    bus.data_write_en  = 1'b0;
    bus.flag_mem_RF    = 1'b0;
    bus.flag_ALU_RF    = 1'b0;
    bus.flag_Rm_RF     = 1'b0;
    bus.flag_PC_RF     = 1'b0;
    bus.RF_write_en    = 1'b0;
    bus.LHI            = 1'b0;
    bus.LLI            = 1'b0;
    bus.flag_OutR      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d          = illegal_q;
`endif

    unique case (state_q)
      ST_LOAD: begin
        bus.test_normal = 1'b1;
        if (bus.start) state_d = ST_RUN;
      end

      ST_RUN: begin
        bus.flag_HLT = 1'b1;
        retire       = 1'b1;
        casez ({op, funct})
          7'b00000_??: begin  // ADD/ADC/SUB/SBB
            bus.ADC         = (funct == 2'b01);
            bus.SUB         = (funct == 2'b10);
            bus.SBB         = (funct == 2'b11);
            bus.flag_ALU_RF = 1'b1;
            bus.RF_write_en = 1'b1;
            flags_d         = {bus.Pre_N, bus.Pre_Z, bus.Pre_C, bus.Pre_V};
          end
          7'b00001_??: begin  // LLI
            bus.LLI         = 1'b1;
            bus.RF_write_en = 1'b1;
          end
          7'b00010_??: begin  // LHI
            bus.LHI         = 1'b1;
            bus.Src_Read_B  = 1'b1;
            bus.RF_write_en = 1'b1;
          end
          7'b00011_??: begin  // LDR
            bus.Src_ALU_B   = 1'b1;
            bus.flag_mem_RF = 1'b1;
            bus.RF_write_en = 1'b1;
          end
          7'b00101_??: begin  // STR
            bus.Src_ALU_B     = 1'b1;
            bus.Src_Read_B    = 1'b1;
            bus.data_write_en = 1'b1;
          end
          7'b00111_??, 7'b01000_??: begin  // ADDI / SUBI
            bus.SUB         = (op == 5'b01000);
            bus.Src_ALU_B   = 1'b1;
            bus.flag_ALU_RF = 1'b1;
            bus.RF_write_en = 1'b1;
            flags_d         = {bus.Pre_N, bus.Pre_Z, bus.Pre_C, bus.Pre_V};
          end
          7'b1100?_??: begin  // Bcond
            bus.BRANCH = cond_true;
          end
          7'b10000_??: begin  // JMP
            bus.JMP           = 1'b1;
            bus.flag_label_PC = 1'b1;
          end
          7'b10001_??: begin  // JAL1
            bus.BRANCH      = 1'b1;
            bus.flag_PC_RF  = 1'b1;
            bus.RF_write_en = 1'b1;
          end
          7'b10010_??: begin  // JAL2
            bus.JMP         = 1'b1;
            bus.flag_Rm_PC  = 1'b1;
            bus.flag_PC_RF  = 1'b1;
            bus.RF_write_en = 1'b1;
          end
          7'b10011_??: begin  // JR
            bus.JMP        = 1'b1;
            bus.flag_Rd_PC = 1'b1;
            bus.Src_Read_B = 1'b1;
          end
          7'b11100_00: begin  // OutR
            bus.flag_OutR = 1'b1;
          end
          7'b11100_01: begin  // HLT: freeze PC now, still retired
            bus.flag_HLT = 1'b0;
            state_d      = ST_HALT;
          end
          default: begin  // undefined opcode
`ifdef ILLEGAL_TRAP_EN
            bus.flag_HLT = 1'b0;
            illegal_d    = 1'b1;
            state_d      = ST_HALT;
            retire       = 1'b0;
`endif
          end
        endcase
        if (retire && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
      end

      ST_HALT: begin
        bus.halted = 1'b1;
        if (bus.start) state_d = ST_LOAD;
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // State, flag register and retired counter; clr overrides everything
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (clr) begin
      state_q <= ST_LOAD;
      flags_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky undefined-opcode flag, cleared only by clr
  always_ff @(posedge clk) begin
    if (clr) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.flags       = flags_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against
// a mode/mnemonic-level reference model.
`timescale 1ns/1ps
module tb_control_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Strobe bit positions in the comparison vector
  localparam int B_ADC = 18, B_SUB = 17, B_SBB = 16, B_JMP = 15, B_BR = 14;
  localparam int B_LBL = 13, B_RMPC = 12, B_RDPC = 11, B_ALUB = 10, B_RDB = 9;
  localparam int B_DWE = 8, B_MEM = 7, B_ALURF = 6, B_RMRF = 5, B_PCRF = 4;
  localparam int B_RFWE = 3, B_LHI = 2, B_LLI = 1, B_OUT = 0;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  control_unit_if #(.CNT_W(CNT_W)) bus ();
  control_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state
  typedef enum {M_LOAD, M_RUN, M_HALT} mode_e;
  mode_e      m_mode;
  int         m_count;
  logic [3:0] m_flags;
  logic       m_illegal;

  typedef struct packed {
    logic [18:0] str;
    logic        writes_flags;
    logic        is_hlt;
    logic        undef;
  } dec_t;

  // Instruction table: which strobes each mnemonic raises
  function automatic dec_t decode(input logic [15:0] i, input logic [3:0] f);
    dec_t d;
    bit   t[16];
    logic n, z, c, v;
    d = '0;
    {n, z, c, v} = f;
    t = '{z, !z, c, !c, n, !n, v, !v, c & !z, !c | z, n == v, n != v,
          !z & (n == v), z | (n != v), 1'b1, 1'b0};
    if (i[15:12] == 4'b1100) d.str[B_BR] = t[i[11:8]];
    else begin
      case (i[15:11])
        5'b00000: begin
          d.str[B_ALURF] = 1; d.str[B_RFWE] = 1; d.writes_flags = 1;
          if (i[1:0] == 2'd1) d.str[B_ADC] = 1;
          if (i[1:0] == 2'd2) d.str[B_SUB] = 1;
          if (i[1:0] == 2'd3) d.str[B_SBB] = 1;
        end
        5'b00001: begin d.str[B_LLI] = 1; d.str[B_RFWE] = 1; end
        5'b00010: begin d.str[B_LHI] = 1; d.str[B_RDB] = 1; d.str[B_RFWE] = 1; end
        5'b00011: begin d.str[B_ALUB] = 1; d.str[B_MEM] = 1; d.str[B_RFWE] = 1; end
        5'b00101: begin d.str[B_ALUB] = 1; d.str[B_RDB] = 1; d.str[B_DWE] = 1; end
        5'b00111: begin
          d.str[B_ALUB] = 1; d.str[B_ALURF] = 1; d.str[B_RFWE] = 1; d.writes_flags = 1;
        end
        5'b01000: begin
          d.str[B_ALUB] = 1; d.str[B_ALURF] = 1; d.str[B_RFWE] = 1; d.str[B_SUB] = 1;
          d.writes_flags = 1;
        end
        5'b10000: begin d.str[B_JMP] = 1; d.str[B_LBL] = 1; end
        5'b10001: begin d.str[B_BR] = 1; d.str[B_PCRF] = 1; d.str[B_RFWE] = 1; end
        5'b10010: begin
          d.str[B_JMP] = 1; d.str[B_RMPC] = 1; d.str[B_PCRF] = 1; d.str[B_RFWE] = 1;
        end
        5'b10011: begin d.str[B_JMP] = 1; d.str[B_RDPC] = 1; d.str[B_RDB] = 1; end
        5'b11100: begin
          if (i[1:0] == 2'd0)      d.str[B_OUT] = 1;
          else if (i[1:0] == 2'd1) d.is_hlt = 1;
          else                     d.undef = 1;
        end
        default: d.undef = 1;
      endcase
    end
    return d;
  endfunction

  function automatic logic [18:0] dut_strobes();
    return {bus.ADC, bus.SUB, bus.SBB, bus.JMP, bus.BRANCH, bus.flag_label_PC,
            bus.flag_Rm_PC, bus.flag_Rd_PC, bus.Src_ALU_B, bus.Src_Read_B,
            bus.data_write_en, bus.flag_mem_RF, bus.flag_ALU_RF, bus.flag_Rm_RF,
            bus.flag_PC_RF, bus.RF_write_en, bus.LHI, bus.LLI, bus.flag_OutR};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold clr for some cycles (start optionally high to show clr wins)
  task automatic apply_clr(input int cycles, input logic st);
    clr       = 1'b1;
    bus.start = st;
    repeat (cycles) @(posedge clk);
    #1;
    clr       = 1'b0;
    bus.start = 1'b0;
    m_mode    = M_LOAD;
    m_count   = 0;
    m_flags   = '0;
    m_illegal = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs mid-cycle, advance the model
  task automatic step(input string tag, input logic [15:0] ins,
                      input logic [3:0] pre, input logic st);
    dec_t        d;
    logic [18:0] e_str;
    logic        e_hlt;
    bit          trap;
    bus.instr = ins;
    {bus.Pre_N, bus.Pre_Z, bus.Pre_C, bus.Pre_V} = pre;
    bus.start = st;
    @(negedge clk);
    d     = decode(ins, m_flags);
    trap  = TRAP_EN && d.undef;
    e_str = (m_mode == M_RUN) ? d.str : '0;
    e_hlt = (m_mode == M_RUN) && !d.is_hlt && !trap;
    check({tag, ".strobes"},     32'(dut_strobes()),     32'(e_str));
    check({tag, ".test_normal"}, 32'(bus.test_normal),   32'(m_mode == M_LOAD));
    check({tag, ".flag_HLT"},    32'(bus.flag_HLT),      32'(e_hlt));
    check({tag, ".halted"},      32'(bus.halted),        32'(m_mode == M_HALT));
    check({tag, ".flags"},       32'(bus.flags),         32'(m_flags));
    check({tag, ".count"},       32'(bus.instr_count),   32'(m_count));
    check({tag, ".illegal"},     32'(bus.illegal),       32'(m_illegal));
    @(posedge clk);
    #1;
    case (m_mode)
      M_LOAD: if (st) m_mode = M_RUN;
      M_RUN: begin
        if (trap) begin
          m_illegal = 1'b1;
          m_mode    = M_HALT;
        end else begin
          if (m_count < CNT_MAX) m_count++;
          if (d.writes_flags) m_flags = pre;
          if (d.is_hlt) m_mode = M_HALT;
        end
      end
      default: if (st) m_mode = M_LOAD;
    endcase
  endtask

  // Walk the machine into RUN using start pulses
  task automatic go_run();
    if (m_mode == M_HALT) step("to_load", 16'h0000, 4'h0, 1'b1);
    if (m_mode == M_LOAD) step("to_run", 16'h0000, 4'h0, 1'b1);
  endtask

  logic [4:0] ops [17] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00101,
                           5'b00111, 5'b01000, 5'b11000, 5'b11001, 5'b10000,
                           5'b10001, 5'b10010, 5'b10011, 5'b11100, 5'b00100,
                           5'b11111, 5'b01101};

  initial begin
    logic [15:0] ri;
    bus.start = 1'b0;
    bus.instr = '0;
    {bus.Pre_N, bus.Pre_Z, bus.Pre_C, bus.Pre_V} = 4'h0;

    // Reset held two cycles with start high: LOAD, zero count/flags
    apply_clr(2, 1'b1);
    step("reset", 16'h0000, 4'h0, 1'b0);

    // Start, then LDR decode and first retirement
    step("start", 16'b00011_001_000_00000, 4'h0, 1'b1);
    step("ldr",   16'b00011_001_000_00000, 4'h0, 1'b0);

    // SUB latches Z, branches read the registered flags
    step("sub",  16'h0306, 4'b0100, 1'b0);
    step("beq",  16'hC007, 4'b1011, 1'b0);
    step("bne",  16'hC107, 4'b0000, 1'b0);
    step("add0", 16'h0000, 4'b0000, 1'b0);
    step("bal",  16'hCE07, 4'b1111, 1'b0);
    step("bnv",  16'hCF07, 4'b0000, 1'b0);

    // HLT: freeze same cycle, halted next, inputs ignored, start -> LOAD
    step("hlt",       16'hE001, 4'h0, 1'b0);
    step("halt_ign",  16'h0306, 4'hF, 1'b0);
    step("halt_strt", 16'h0000, 4'h0, 1'b1);
    step("load_strt", 16'h0000, 4'h0, 1'b1);
    step("run1",      16'h3800, 4'b1001, 1'b0);

    // clr during RUN returns to LOAD with count cleared
    apply_clr(1, 1'b0);
    step("after_clr", 16'h0000, 4'h0, 1'b0);

    // Undefined opcode in RUN
    go_run();
    step("undef",      16'hF800, 4'h0, 1'b0);
    step("post_undef", 16'h0000, 4'h0, 1'b0);

    // Counter saturation
    go_run();
    repeat (20) step("sat", 16'h3800, 4'($urandom), 1'b0);

    // Randomized instruction stream with occasional start pulses and clr
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 60) == 0) apply_clr(1, 1'($urandom));
      ri = {ops[$urandom_range(0, 16)], 11'($urandom)};
      step("rand", ri, 4'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
